regression_mac: RTL

Sequential multiply-accumulate stage of the linear-regression datapath: computes y = bias + Σ x_i·w_i over N_FEATURES unsigned 8-bit feature/weight pairs. Each product comes from an 8-cycle shift-and-add multiplier. It is then accumulated through one additionneur_16bit instance, whose carry-out drives a sticky overflow flag. The block sits between the feature/weight source (valid/ready) and the prediction consumer (valid/ready).

---
 rtl/regression_mac_if.sv | 27 ++
 rtl/regression_mac.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/regression_mac_if.sv
// Handshake and data bundle between the feature/weight source, the
// regression MAC stage and the prediction consumer.
interface regression_mac_if;
    logic        start;
    logic [15:0] bias;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  x;
    logic [7:0]  w;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y;
    logic        overflow;
    logic        busy;

    // Producer/consumer side: drives the request and pairs, observes the result.
    modport master (
        output start, bias, in_valid, x, w, out_ready,
        input  in_ready, out_valid, y, overflow, busy
    );

    // MAC side.
    modport slave (
        input  start, bias, in_valid, x, w, out_ready,
        output in_ready, out_valid, y, overflow, busy
    );
endinterface

// File: rtl/regression_mac.sv
// Sequential multiply-accumulate stage of the linear-regression datapath:
// y = bias + sum(x_i * w_i) over N_FEATURES unsigned 8-bit pairs. Each product
// comes from an 8-cycle shift-and-add multiplier. It is then folded into the
// accumulator through a single 16-bit adder, whose carry-out sets a sticky
// overflow flag.

// 16-bit adder with carry in/out; the carry-out is what feeds the overflow flag.
module additionneur_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        rin,
    output logic [15:0] s,
    output logic        rout
);
    assign {rout, s} = {1'b0, a} + {1'b0, b} + {16'd0, rin};
endmodule

module regression_mac #(
    parameter int N_FEATURES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    regression_mac_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCEPT = 3'd1,
        MUL    = 3'd2,
        ADD    = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Value of the pair counter while the last pair is being added.
    localparam logic [7:0] LAST_CNT = 8'(N_FEATURES - 1);

    state_t      state_reg;
    state_t      state_next;
    logic [15:0] acc_reg;
    logic [15:0] prod_reg;
    logic [7:0]  xr_reg;
    logic [7:0]  wr_reg;
    logic [7:0]  cnt_reg;
    logic [2:0]  bit_reg;
    logic        ovf_reg;

    logic [15:0] sum;
    logic        carry;
    logic [15:0] partial;

    // Shifted multiplicand for the current multiplier bit; the largest running
    // product is 255*255, so the 16-bit add in MUL never overflows.
    assign partial = {8'd0, xr_reg} << bit_reg;

    additionneur_16bit u_add (
        .a    (acc_reg),
        .b    (prod_reg),
        .rin  (1'b0),
        .s    (sum),
        .rout (carry)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode; start is only looked at in IDLE, in_valid only in ACCEPT.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start)     state_next = ACCEPT;
            ACCEPT:  if (bus.in_valid)  state_next = MUL;
            MUL:     if (bit_reg == 3'd7) state_next = ADD;
            ADD:     state_next = (cnt_reg == LAST_CNT) ? DONE : ACCEPT;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded purely from the state.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        case (state_reg)
            IDLE:    bus.busy      = 1'b0;
            ACCEPT:  bus.in_ready  = 1'b1;
            DONE:    bus.out_valid = 1'b1;
            default: bus.busy      = 1'b1;
        endcase
    end

    // Datapath: latch bias/pairs, shift-and-add multiply, accumulate with sticky carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg  <= 16'd0;
            prod_reg <= 16'd0;
            xr_reg   <= 8'd0;
            wr_reg   <= 8'd0;
            cnt_reg  <= 8'd0;
            bit_reg  <= 3'd0;
            ovf_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        acc_reg <= bus.bias;
                        cnt_reg <= 8'd0;
                        ovf_reg <= 1'b0;
                    end
                end
                ACCEPT: begin
                    if (bus.in_valid) begin
                        xr_reg   <= bus.x;
                        wr_reg   <= bus.w;
                        prod_reg <= 16'd0;
                        bit_reg  <= 3'd0;
                    end
                end
                MUL: begin
                    if (wr_reg[bit_reg]) begin
                        prod_reg <= prod_reg + partial;
                    end
                    bit_reg <= bit_reg + 3'd1;
                end
                ADD: begin
                    acc_reg <= sum;
                    ovf_reg <= ovf_reg | carry;
                    cnt_reg <= cnt_reg + 8'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Result is the accumulator itself; it only changes in IDLE/ADD, so it is
    // stable for the whole time DONE waits on the consumer.
    assign bus.y        = acc_reg;
    assign bus.overflow = ovf_reg;

endmodule
